control_sequencer: RTL and testbench

- Hardwired control unit that drives every control input of the Phase 1 datapath: register in/out strobes, bus selects, ALU op, MUL/DIV select and memory Read.
- Sequences fetch (T0–T2) and execute (T3–T6) from the IR value fed back from the datapath.
- Waits on a memory-done handshake during fetch.
- Sits beside the datapath at the top level; its outputs wire one-to-one to the datapath's control inputs.

---
 rtl/cpu_ctrl_pkg.sv | 36 +++
 rtl/decoder_4to16.sv | 9 +
 rtl/control_sequencer.sv | 158 +++++++++++++++
 tb/tb_control_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: opcodes, ALU codes, sequencer states and opcode classification
package cpu_ctrl_pkg;
  localparam logic [4:0] OP_ADD  = 5'h03;
  localparam logic [4:0] OP_SUB  = 5'h04;
  localparam logic [4:0] OP_AND  = 5'h05;
  localparam logic [4:0] OP_OR   = 5'h06;
  localparam logic [4:0] OP_SHR  = 5'h07;
  localparam logic [4:0] OP_SHL  = 5'h09;
  localparam logic [4:0] OP_MUL  = 5'h0F;
  localparam logic [4:0] OP_DIV  = 5'h10;
  localparam logic [4:0] OP_MFHI = 5'h18;
  localparam logic [4:0] OP_MFLO = 5'h19;
  localparam logic [4:0] OP_NOP  = 5'h1A;
  localparam logic [4:0] OP_HALT = 5'h1B;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_SHR  = 4'd4;
  localparam logic [3:0] ALU_SHL  = 4'd5;
  localparam logic [3:0] ALU_INCB = 4'd6;
  typedef enum logic [3:0] {S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT} state_e;
  function automatic logic [3:0] alu_of(input logic [4:0] op);
    return op == OP_SUB ? ALU_SUB :
           op == OP_AND ? ALU_AND :
           op == OP_OR  ? ALU_OR  :
           op == OP_SHR ? ALU_SHR :
           op == OP_SHL ? ALU_SHL : ALU_ADD;
  endfunction
  function automatic logic is_alu(input logic [4:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL};
  endfunction
  function automatic logic is_muldiv(input logic [4:0] op);
    return op inside {OP_MUL, OP_DIV};
  endfunction
endpackage

// File: rtl/decoder_4to16.sv
// decoder_4to16: one-hot register select
//   sel: register index, en: enable, y: one-hot select (all zero when en=0)
module decoder_4to16 (
  input  logic [3:0]  sel,
  input  logic        en,
  output logic [15:0] y
);
  assign y = en ? 16'(1) << sel : 16'h0000;
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/execute control unit for the Phase 1 datapath
//   clock/clear: clock and sync active-high reset; run: start/continue issuing
//   ir: IR feedback; mem_done: fetched word is on Mdatain
//   Rin/Rout: one-hot GPR strobes; remaining strobes wire 1:1 to the datapath
//   busy: in a T-state; instr_done: last execute cycle; fault: sticky error
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 16,
  parameter int WCNT_W     = 5
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_done,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic        MARin,
  output logic        PCin,
  output logic        PCout,
  output logic        IRin,
  output logic        IRout,
  output logic        Yin,
  output logic        Yout,
  output logic        MDRin,
  output logic        MDRout,
  output logic        HIin,
  output logic        HIout,
  output logic        LOin,
  output logic        LOout,
  output logic        Zhighin,
  output logic        Zlowin,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        Read,
  output logic [3:0]  ALUop,
  output logic        ALU_MUL,
  output logic        ALU_DIV,
  output logic        busy,
  output logic        instr_done,
  output logic        fault
);
  state_e state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d, wcnt_inc;
  logic fault_q, fault_d;
  logic rin_en, rout_en;
  logic [3:0] rin_sel, rout_sel;
  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic unused_ir;
  assign op = ir[31:27];
  assign ra = ir[26:23];
  assign rb = ir[22:19];
  assign rc = ir[18:15];
  assign unused_ir = ^ir[14:0];
  assign wcnt_inc = wcnt_q + 1'b1;
  assign fault = fault_q;
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      fault_q <= fault_d;
    end
  end
  // Counter only survives while still waiting in T1; every other path clears it.
  always_comb begin
    state_d = state_q;
    wcnt_d  = '0;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: state_d = run ? S_T0 : S_IDLE;
      S_T0:   state_d = S_T1;
      S_T1: begin
        if (mem_done) state_d = S_T2;
        else if (wcnt_inc == WCNT_W'(WAIT_LIMIT)) begin
          state_d = S_HALT;
          fault_d = 1'b1;
        end else wcnt_d = wcnt_inc;
      end
      S_T2: state_d = S_T3;
      S_T3: begin
        if (is_alu(op) || is_muldiv(op)) state_d = S_T4;
        else if (!instr_done) begin
          state_d = S_HALT;
          fault_d = op != OP_HALT;
        end
      end
      S_T4: state_d = S_T5;
      S_T5: state_d = is_muldiv(op) ? S_T6 : state_q;
      default: state_d = state_q;
    endcase
    if (instr_done) state_d = run ? S_T0 : S_IDLE;
  end
  always_comb begin
    {MARin, PCin, PCout, IRin, IRout, Yin, Yout, MDRin, MDRout, HIin, HIout, LOin, LOout,
     Zhighin, Zlowin, Zhighout, Zlowout, Read, ALU_MUL, ALU_DIV, instr_done} = '0;
    ALUop    = ALU_ADD;
    rin_en   = 1'b0;
    rin_sel  = ra;
    rout_en  = 1'b0;
    rout_sel = rb;
    busy     = !(state_q inside {S_IDLE, S_HALT});
    case (state_q)
      S_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        ALUop  = ALU_INCB;
        Zlowin = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        rout_en    = is_alu(op) || is_muldiv(op);
        Yin        = rout_en;
        HIout      = op == OP_MFHI;
        LOout      = op == OP_MFLO;
        rin_en     = HIout || LOout;
        instr_done = rin_en || op == OP_NOP;
      end
      S_T4: begin
        rout_en  = 1'b1;
        rout_sel = rc;
        Zlowin   = 1'b1;
        Zhighin  = is_muldiv(op);
        ALU_MUL  = op == OP_MUL;
        ALU_DIV  = op == OP_DIV;
        ALUop    = alu_of(op);
      end
      S_T5: begin
        Zlowout    = 1'b1;
        LOin       = is_muldiv(op);
        rin_en     = !LOin;
        instr_done = rin_en;
      end
      S_T6: begin
        Zhighout   = 1'b1;
        HIin       = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end
  decoder_4to16 u_rin  (.sel(rin_sel),  .en(rin_en),  .y(Rin));
  decoder_4to16 u_rout (.sel(rout_sel), .en(rout_en), .y(Rout));
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: per-instruction expected control traces checked cycle by cycle
module tb_control_sequencer;
  localparam int WAIT_LIMIT = 16;
  typedef struct packed {
    logic [15:0] rin, rout;
    logic marin, pcin, pcout, irin, irout, yin, yout, mdrin, mdrout;
    logic hiin, hiout, loin, loout, zhighin, zlowin, zhighout, zlowout, read;
    logic [3:0] aluop;
    logic mul, div, busy, done, fault;
  } ctl_t;
  typedef struct packed {
    ctl_t c;
    logic md;
    logic run;
    logic [31:0] ir;
  } ent_t;
  logic clock = 1'b0, clear = 1'b1, run = 1'b0, mem_done = 1'b0;
  logic [31:0] ir = '0;
  logic [15:0] Rin, Rout;
  logic MARin, PCin, PCout, IRin, IRout, Yin, Yout, MDRin, MDRout, HIin, HIout, LOin, LOout;
  logic Zhighin, Zlowin, Zhighout, Zlowout, Read, ALU_MUL, ALU_DIV, busy, instr_done, fault;
  logic [3:0] ALUop;
  ctl_t obs;
  ent_t exp_q[$];
  ctl_t got_q[$];
  int tests = 0, failed = 0;
  logic m_fault = 1'b0;
  logic [4:0] alu_ops [6] = '{5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h09};
  logic [4:0] legal_ops [11] = '{5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h09, 5'h0F, 5'h10, 5'h18, 5'h19, 5'h1A};
  always #5 clock = ~clock;
  control_sequencer #(.WAIT_LIMIT(WAIT_LIMIT), .WCNT_W(5)) dut (
    .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_done(mem_done),
    .Rin(Rin), .Rout(Rout), .MARin(MARin), .PCin(PCin), .PCout(PCout), .IRin(IRin),
    .IRout(IRout), .Yin(Yin), .Yout(Yout), .MDRin(MDRin), .MDRout(MDRout), .HIin(HIin),
    .HIout(HIout), .LOin(LOin), .LOout(LOout), .Zhighin(Zhighin), .Zlowin(Zlowin),
    .Zhighout(Zhighout), .Zlowout(Zlowout), .Read(Read), .ALUop(ALUop), .ALU_MUL(ALU_MUL),
    .ALU_DIV(ALU_DIV), .busy(busy), .instr_done(instr_done), .fault(fault)
  );
  assign obs = {Rin, Rout, MARin, PCin, PCout, IRin, IRout, Yin, Yout, MDRin, MDRout,
                HIin, HIout, LOin, LOout, Zhighin, Zlowin, Zhighout, Zlowout, Read,
                ALUop, ALU_MUL, ALU_DIV, busy, instr_done, fault};
  function automatic void push(input ctl_t c, input logic md, input logic r, input logic [31:0] iv);
    ent_t e;
    e.c = c; e.md = md; e.run = r; e.ir = iv;
    exp_q.push_back(e);
  endfunction
  function automatic void halt_tail(input logic [31:0] iv);
    ctl_t c;
    for (int k = 0; k < 3; k++) begin
      c = '0; c.fault = m_fault;
      push(c, 1'b0, 1'b0, iv);
    end
  endfunction
  function automatic void idle_tail(input logic [31:0] iv);
    ctl_t c;
    c = '0;
    push(c, 1'b0, 1'b0, iv);
  endfunction
  // Expected cycle-by-cycle controls for one instruction, from T0 onward.
  function automatic void build(input logic [31:0] iv, input int waits, input logic chain);
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    int ai;
    logic mdv;
    ctl_t c;
    op = iv[31:27]; ra = iv[26:23]; rb = iv[22:19]; rc = iv[18:15];
    ai = -1;
    for (int k = 0; k < 6; k++) if (alu_ops[k] == op) ai = k;
    mdv = op == 5'h0F || op == 5'h10;
    c = '0; c.busy = 1; c.pcout = 1; c.marin = 1; c.aluop = 4'd6; c.zlowin = 1;
    push(c, 1'b0, chain, iv);
    for (int i = 0; i <= waits && i < WAIT_LIMIT; i++) begin
      c = '0; c.busy = 1; c.zlowout = 1; c.pcin = 1; c.read = 1; c.mdrin = 1;
      push(c, i == waits, chain, iv);
    end
    if (waits >= WAIT_LIMIT) begin
      m_fault = 1'b1;
      halt_tail(iv);
      return;
    end
    c = '0; c.busy = 1; c.mdrout = 1; c.irin = 1;
    push(c, 1'b0, chain, iv);
    c = '0; c.busy = 1;
    if (ai >= 0 || mdv) begin c.rout = 16'(1) << rb; c.yin = 1; end
    else if (op == 5'h18) begin c.hiout = 1; c.rin = 16'(1) << ra; c.done = 1; end
    else if (op == 5'h19) begin c.loout = 1; c.rin = 16'(1) << ra; c.done = 1; end
    else if (op == 5'h1A) c.done = 1;
    push(c, 1'b0, chain, iv);
    if (ai < 0 && !mdv) begin
      if (!c.done) begin
        m_fault = op != 5'h1B;
        halt_tail(iv);
      end else if (!chain) idle_tail(iv);
      return;
    end
    c = '0; c.busy = 1; c.rout = 16'(1) << rc; c.zlowin = 1;
    if (mdv) begin c.mul = op == 5'h0F; c.div = op == 5'h10; c.zhighin = 1; end
    else c.aluop = 4'(ai);
    push(c, 1'b0, chain, iv);
    c = '0; c.busy = 1; c.zlowout = 1;
    if (mdv) c.loin = 1;
    else begin c.rin = 16'(1) << ra; c.done = 1; end
    push(c, 1'b0, chain, iv);
    if (mdv) begin
      c = '0; c.busy = 1; c.zhighout = 1; c.hiin = 1; c.done = 1;
      push(c, 1'b0, chain, iv);
    end
    if (!chain) idle_tail(iv);
  endfunction
  task automatic start();
    ir = exp_q[0].ir;
    run = 1'b1;
    mem_done = 1'b0;
  endtask
  task automatic play();
    got_q.delete();
    foreach (exp_q[i]) begin
      @(posedge clock); #1;
      got_q.push_back(obs);
      run = exp_q[i].run;
      mem_done = exp_q[i].md;
      ir = exp_q[i].ir;
    end
  endtask
  task automatic do_clear();
    clear = 1'b1; run = 1'b0; mem_done = 1'b0;
    @(posedge clock); #1;
    clear = 1'b0;
    m_fault = 1'b0;
  endtask
  task automatic test_reset();
    clear = 1'b1; run = 1'b0; mem_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) clear = 1'b0;
      @(posedge clock); #1;
      tests++;
      if (obs !== '0) begin failed++; $display("FAIL reset cycle %0d: got %h, expected 0", i, obs); end
    end
  endtask
  task automatic test_add();
    exp_q.delete();
    build(32'h18918000, 0, 1'b0);
    start(); play();
    foreach (exp_q[i]) begin
      tests++;
      if (got_q[i] !== exp_q[i].c) begin failed++; $display("FAIL add cycle %0d: got %h, expected %h", i, got_q[i], exp_q[i].c); end
    end
    tests++;
    if (got_q[0].aluop !== 4'd6 || got_q[0].pcout !== 1'b1) begin failed++; $display("FAIL add_t0: aluop %0d pcout %b, expected 6 1", got_q[0].aluop, got_q[0].pcout); end
    tests++;
    if (got_q[3].rout !== 16'h0004 || got_q[3].yin !== 1'b1) begin failed++; $display("FAIL add_t3: rout %h yin %b, expected 0004 1", got_q[3].rout, got_q[3].yin); end
    tests++;
    if (got_q[4].rout !== 16'h0008 || got_q[4].aluop !== 4'd0) begin failed++; $display("FAIL add_t4: rout %h aluop %0d, expected 0008 0", got_q[4].rout, got_q[4].aluop); end
    tests++;
    if (got_q[5].rin !== 16'h0002 || got_q[5].done !== 1'b1) begin failed++; $display("FAIL add_t5: rin %h done %b, expected 0002 1", got_q[5].rin, got_q[5].done); end
  endtask
  task automatic test_mul_wait();
    int reads;
    exp_q.delete();
    build({5'h0F, 4'd4, 4'd5, 4'd6, 15'd0}, 3, 1'b0);
    start(); play();
    foreach (exp_q[i]) begin
      tests++;
      if (got_q[i] !== exp_q[i].c) begin failed++; $display("FAIL mul_wait cycle %0d: got %h, expected %h", i, got_q[i], exp_q[i].c); end
    end
    reads = 0;
    foreach (got_q[i]) if (got_q[i].read === 1'b1 && got_q[i].mdrin === 1'b1) reads++;
    tests++;
    if (reads != 4) begin failed++; $display("FAIL mul_read_cycles: got %0d, expected 4", reads); end
    tests++;
    if (got_q[8].loin !== 1'b1 || got_q[9].hiin !== 1'b1 || got_q[9].done !== 1'b1) begin failed++; $display("FAIL mul_lohi: t5 loin %b t6 hiin %b done %b, expected 1 1 1", got_q[8].loin, got_q[9].hiin, got_q[9].done); end
  endtask
  task automatic test_wait_boundary();
    exp_q.delete();
    build({5'h04, 4'd7, 4'd8, 4'd9, 15'd0}, WAIT_LIMIT - 1, 1'b0);
    start(); play();
    foreach (exp_q[i]) begin
      tests++;
      if (got_q[i] !== exp_q[i].c) begin failed++; $display("FAIL wait_15 cycle %0d: got %h, expected %h", i, got_q[i], exp_q[i].c); end
    end
  endtask
  task automatic test_timeout();
    exp_q.delete();
    build({5'h03, 27'd0}, 1000, 1'b0);
    start(); play();
    foreach (exp_q[i]) begin
      tests++;
      if (got_q[i] !== exp_q[i].c) begin failed++; $display("FAIL timeout cycle %0d: got %h, expected %h", i, got_q[i], exp_q[i].c); end
    end
    tests++;
    if (got_q[17].fault !== 1'b1 || got_q[17].busy !== 1'b0) begin failed++; $display("FAIL timeout_halt: fault %b busy %b, expected 1 0", got_q[17].fault, got_q[17].busy); end
    do_clear();
    tests++;
    if (obs !== '0) begin failed++; $display("FAIL timeout_clear: got %h, expected 0", obs); end
  endtask
  task automatic test_halt_ops();
    logic [4:0] ops [2] = '{5'h1F, 5'h1B};
    logic fx [2] = '{1'b1, 1'b0};
    for (int t = 0; t < 2; t++) begin
      exp_q.delete();
      build({ops[t], 27'h12345}, $urandom_range(0, 2), 1'b0);
      start(); play();
      foreach (exp_q[i]) begin
        tests++;
        if (got_q[i] !== exp_q[i].c) begin failed++; $display("FAIL halt_op %h cycle %0d: got %h, expected %h", ops[t], i, got_q[i], exp_q[i].c); end
      end
      tests++;
      if (fault !== fx[t]) begin failed++; $display("FAIL halt_fault %h: got %b, expected %b", ops[t], fault, fx[t]); end
      do_clear();
      tests++;
      if (obs !== '0) begin failed++; $display("FAIL halt_clear %h: got %h, expected 0", ops[t], obs); end
    end
  endtask
  task automatic test_clear_div();
    exp_q.delete();
    build({5'h10, 4'd1, 4'd2, 4'd3, 15'd0}, 1, 1'b0);
    while (exp_q.size() > 6) void'(exp_q.pop_back());
    start(); play();
    foreach (exp_q[i]) begin
      tests++;
      if (got_q[i] !== exp_q[i].c) begin failed++; $display("FAIL clr_div cycle %0d: got %h, expected %h", i, got_q[i], exp_q[i].c); end
    end
    clear = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      clear = 1'b0;
      tests++;
      if (obs !== '0) begin failed++; $display("FAIL clr_div_after %0d: got %h, expected 0", i, obs); end
    end
  endtask
  task automatic test_back_to_back();
    int n;
    for (int b = 0; b < 8; b++) begin
      exp_q.delete();
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++)
        build({legal_ops[$urandom_range(0, 10)], 27'($urandom)}, $urandom_range(0, 3), j < n - 1);
      start(); play();
      foreach (exp_q[i]) begin
        tests++;
        if (got_q[i] !== exp_q[i].c) begin failed++; $display("FAIL b2b batch %0d cycle %0d: got %h, expected %h", b, i, got_q[i], exp_q[i].c); end
      end
    end
  endtask
  initial begin
    test_reset();
    test_add();
    test_mul_wait();
    test_wait_boundary();
    test_timeout();
    test_halt_ops();
    test_clear_div();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
